// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding, default bus widths and
// command/response payloads used by the master and by apb_slave benches.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// ACCESS wait-state counter. expired_o is registered and is high exactly when
// the next increment would land on TIMEOUT-1, i.e. this is the last cycle to wait.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  // Counter saturates once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      expired_q <= (LIMIT == '0);
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == LIMIT);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/apb_master.sv
// APB3 master: turns single-beat valid/ready commands into SETUP/ACCESS
// transfers and returns PRDATA/PSLVERR (or a timeout) on a response channel.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  output logic              PSELx,
  output logic              PENABLE,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_mst_state_t    state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expired;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (i_clk),
    .rst_ni    (i_reset_n),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state and next-output logic; address/data hold their last values.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (i_cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          paddr_d     = i_cmd_addr;
          pwrite_d    = i_cmd_write;
          pwdata_d    = i_cmd_wdata;
          psel_d      = 1'b1;
          timer_clr   = 1'b1;
          state_d     = SETUP;
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      // PREADY takes priority over the timer on the final allowed cycle.
      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else if (timer_expired) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          state_d       = RESP;
        end else begin
          timer_en = 1'b1;
        end
      end

      RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          timer_clr   = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_cmd_ready   = cmd_ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign PADDR         = paddr_q;
  assign PWRITE        = pwrite_q;
  assign PWDATA        = pwdata_q;
  assign PSELx         = psel_q;
  assign PENABLE       = penable_q;

endmodule
